// File: rtl/pico_io_responder.sv
// Port-mapped peripheral on the KCPSM3 port bus: LED register, synchronized
// switch input with sticky change flags, a producer-filled byte FIFO drained
// by processor reads, and a maskable level interrupt.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   port_id[7:0]       processor port address
//   write_strobe       one-cycle write qualifier
//   read_strobe        one-cycle read qualifier (read side effects)
//   out_port[7:0]      processor write data
//   in_port[7:0]       registered read data, in_port(t+1) = reg[port_id(t)]
//   interrupt          registered interrupt request
//   interrupt_ack      one-cycle acknowledge
//   sw[7:0]            asynchronous switch inputs
//   led[7:0]           LED drive
//   wr_data[7:0]       producer byte
//   wr_valid           producer write request
//   wr_ready           FIFO can accept (combinational ~full)
//
// Register map (offset from BASE_ADDR):
//   0 LED (R/W), 1 SW (R), 2 SW_CHG (R, clear-on-read), 3 FIFO_DATA (R, pop),
//   4 STATUS {ovf, full, empty, count[4:0]} (R; write bit7 clears ovf),
//   5 IRQ_MASK (R/W, bits [1:0])
module pico_io_responder #(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic [7:0] sw,
    output logic [7:0] led,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SYNC_W = 8 * SYNC_STAGES;

    localparam logic [7:0] OFF_LED    = 8'd0;
    localparam logic [7:0] OFF_SW     = 8'd1;
    localparam logic [7:0] OFF_SW_CHG = 8'd2;
    localparam logic [7:0] OFF_FIFO   = 8'd3;
    localparam logic [7:0] OFF_STATUS = 8'd4;
    localparam logic [7:0] OFF_MASK   = 8'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]        r_led;
    logic [7:0]        r_in_port;
    logic [1:0]        r_irq_mask;
    logic              r_irq;
    logic [SYNC_W-1:0] r_sync;
    logic [7:0]        r_sw_prev;
    logic [7:0]        r_sw_chg;
    logic              r_ovf;
    logic              r_full;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [7:0]        r_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic [7:0]       w_offset;
    logic             w_sel_led;
    logic             w_sel_sw_chg;
    logic             w_sel_fifo;
    logic             w_sel_status;
    logic             w_sel_mask;
    logic [7:0]       w_sw_s;
    logic [7:0]       w_chg_set;
    logic [7:0]       w_chg_clr;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_ovf_set;
    logic             w_ovf_clr;
    logic             w_irq_cond;
    logic [7:0]       w_rd_data;

    // Address decode relative to the base; anything outside 0..5 is unmapped.
    assign w_offset     = port_id - BASE_ADDR;
    assign w_sel_led    = (w_offset == OFF_LED);
    assign w_sel_sw_chg = (w_offset == OFF_SW_CHG);
    assign w_sel_fifo   = (w_offset == OFF_FIFO);
    assign w_sel_status = (w_offset == OFF_STATUS);
    assign w_sel_mask   = (w_offset == OFF_MASK);

    // Switch synchronizer output and per-bit change detection.
    assign w_sw_s    = r_sync[SYNC_W-1 -: 8];
    assign w_chg_set = w_sw_s ^ r_sw_prev;
    // Clear exactly the bits being returned by this read; a same-cycle set wins.
    assign w_chg_clr = (read_strobe && w_sel_sw_chg) ? r_sw_chg : 8'h00;

    // FIFO handshake; pop only on a strobed FIFO_DATA read when not empty.
    assign w_empty  = (r_count == '0);
    assign w_push   = wr_valid & ~r_full;
    assign w_pop    = read_strobe & w_sel_fifo & ~w_empty;
    assign w_ovf_set = wr_valid & r_full;
    assign w_ovf_clr = write_strobe & w_sel_status & out_port[7];

    // Interrupt condition from registered state only.
    assign w_irq_cond = (r_irq_mask[0] & ~w_empty) | (r_irq_mask[1] & (|r_sw_chg));

    // Next FIFO occupancy.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Read data mux for the current port_id.
    always_comb begin
        w_rd_data = 8'h00;
        case (w_offset)
            OFF_LED:    w_rd_data = r_led;
            OFF_SW:     w_rd_data = w_sw_s;
            OFF_SW_CHG: w_rd_data = r_sw_chg;
            OFF_FIFO:   w_rd_data = w_empty ? 8'h00 : r_mem[r_rptr];
            OFF_STATUS: w_rd_data = {r_ovf, r_full, w_empty, 5'(r_count)};
            OFF_MASK:   w_rd_data = {6'd0, r_irq_mask};
            default:    w_rd_data = 8'h00;
        endcase
    end

    // Processor-visible registers: read data, LED, mask, interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_port  <= 8'h00;
            r_led      <= 8'h00;
            r_irq_mask <= 2'b00;
            r_irq      <= 1'b0;
        end else begin
            r_in_port <= w_rd_data;
            if (write_strobe && w_sel_led) begin
                r_led <= out_port;
            end
            if (write_strobe && w_sel_mask) begin
                r_irq_mask <= out_port[1:0];
            end
            // Acknowledge forces at least one low cycle before re-assertion.
            r_irq <= ~interrupt_ack & w_irq_cond;
        end
    end

    // Switch synchronizer chain and sticky change flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= '0;
            r_sw_prev <= 8'h00;
            r_sw_chg  <= 8'h00;
        end else begin
            r_sync    <= {r_sync[SYNC_W-9:0], sw};
            r_sw_prev <= w_sw_s;
            r_sw_chg  <= (r_sw_chg & ~w_chg_clr) | w_chg_set;
        end
    end

    // FIFO pointers, occupancy, full and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            // A drop in the same cycle as the clear keeps the flag set.
            r_ovf   <= w_ovf_set | (r_ovf & ~w_ovf_clr);
        end
    end

    // FIFO storage; contents are meaningless once pointers reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    assign in_port   = r_in_port;
    assign led       = r_led;
    assign interrupt = r_irq;
    assign wr_ready  = ~r_full;

endmodule
